reg_file: RTL and testbench
===========================

# reg_file

32 × 32-bit general-purpose register file for the single-cycle CPU datapath. It sits directly upstream of the ALU operand-B 2:1 32-bit selector, and its second read port drives that selector's `A0` input. It provides two combinational read ports, one synchronous write port and one combinational debug read port. Register 0 is hard-wired to zero.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register.
- `AW`, 5, address width; the depth is 2^AW = 32 entries.

Ports:
- `Clk`, input, 1 bit: the only clock. All writes happen on its rising edge.
- `Clrn`, input, 1 bit: reset, asynchronous and active-low. It clears every register.
- `We`, input, 1 bit: write enable, sampled on the rising edge of `Clk`.
- `Wa`, input, AW bits: write address.
- `D`, input, WIDTH bits: write data.
- `Ra1`, input, AW bits: read address for port A (rs).
- `Ra2`, input, AW bits: read address for port B (rt).
- `Qa`, output, WIDTH bits: port A read data, combinational.
- `Qb`, output, WIDTH bits: port B read data, combinational. Feeds the ALU-B selector `A0`.
- `Dbg_a`, input, AW bits: debug read address, used by the board display and the bench.
- `Dbg_q`, output, WIDTH bits: debug read data, combinational.

## Operation
- Storage is registers 1..31. Register 0 is not stored. Any read of address 0 returns 0 on every port.
- Write: on the rising edge of `Clk`, if `Clrn`=1 and `We`=1 and `Wa`≠0, then reg[`Wa`] ← `D`.
  - A write with `Wa`=0 is silently discarded.
  - A write with `We`=0 changes nothing.
- Read: `Qa` = reg[`Ra1`], `Qb` = reg[`Ra2`], `Dbg_q` = reg[`Dbg_a`].
  - All three are purely combinational from the current register contents and address.
- No write-to-read bypass.
  - Reason: in the single-cycle datapath `D` is derived from `Qa`/`Qb` through the ALU and memory, so a bypass would form a combinational loop.
  - Consequence: a read of the address being written returns the old value until the write edge.
- All three read ports are independent. Any combination of equal or differing addresses is legal, including all three equal to `Wa`.
- Reset: when `Clrn`=0, all registers 1..31 become 0 immediately, with no clock needed. Writes are blocked for as long as `Clrn`=0.
- Every address value 0..31 is legal. There is no out-of-range case.

## Timing
- Reset values: `Qa`, `Qb` and `Dbg_q` all read 0 whenever `Clrn`=0, and remain 0 after release until the first write, for any address.
- Write latency: new data is visible on every read port one combinational delay after the rising edge that captures it.
- Read latency: zero cycles from the address. Outputs track `Ra1`, `Ra2` and `Dbg_a` combinationally.
- Reset assertion mid-cycle: contents clear asynchronously and outputs drop to 0 within the same cycle.
- Reset assertion and write enable together: if `Clrn` falls in the same cycle as a pending `We`=1, no write occurs and the contents stay 0.
- Reset release: if `Clrn` rises before a rising edge with `We`=1, the write at that edge is performed normally. Release must meet the recovery time against `Clk`.
- Reset release timing vs. same-edge writes: release coincident with a rising edge must be avoided by the system. The bench drives `Clrn` on the falling edge of `Clk`.
- Back-to-back writes to the same address on consecutive edges: the last write wins, and each value is visible for exactly one cycle.

## Test plan
- Reset clears everything: write 0xDEADBEEF to r5, then pulse `Clrn` low mid-cycle with no clock edge. Required: `Qa` (`Ra1`=5) drops to 0 within the same cycle, and `Dbg_q` at every address reads 0.
- Write and read back: write r7 = 0x12345678 with `We`=1, then set `Ra1`=7, `Ra2`=7, `Dbg_a`=7. Required: all three ports read 0x12345678 after the edge; before the edge, `Qa` still reads the old value 0.
- r0 protection: write 0xFFFFFFFF with `Wa`=0 and `We`=1. Required: `Qa`, `Qb` and `Dbg_q` at address 0 read 0x00000000.
- Write enable gating: `We`=0, `Wa`=3, `D`=0xA5A5A5A5 over 4 edges. Required: r3 remains at its prior value of 0x00000011.
- Full sweep: write reg[i] = i×0x01010101 for i = 1..31, then read all 32 addresses on `Ra1`/`Ra2` crossed (e.g. `Ra1`=i, `Ra2`=31−i). Required: each port returns the expected pattern, and address 0 returns 0.
- No bypass / consecutive writes: r9 = 0x1 at edge n, then r9 = 0x2 at edge n+1, with `Ra2`=9 held. Required: `Qb` = 0x1 during cycle n+1 and 0x2 from edge n+1 on, with no combinational path from `D` to `Qb`.

Source files
------------

// File: rtl/reg_file.sv
// 32x32 register file, r0 hard-wired to zero; two read ports plus one debug read port.
// Reads are combinational with no write bypass; writes land on the rising Clk edge; no backpressure.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             We,
  input  logic [AW-1:0]    Wa,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    Ra1,
  input  logic [AW-1:0]    Ra2,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  input  logic [AW-1:0]    Dbg_a,
  output logic [WIDTH-1:0] Dbg_q
);

  localparam int DEPTH = 1 << AW;

  // Entry 0 has no storage; reads of address 0 are forced to zero below.
  logic [WIDTH-1:0] regs [1:DEPTH-1];

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (We && (Wa != '0)) begin
      regs[Wa] <= D;
    end
  end

  // Read straight from storage: D is derived from Qa/Qb downstream, so a bypass would loop.
  assign Qa    = (Ra1   == '0) ? '0 : regs[Ra1];
  assign Qb    = (Ra2   == '0) ? '0 : regs[Ra2];
  assign Dbg_q = (Dbg_a == '0) ? '0 : regs[Dbg_a];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected port values, a monitor pops and compares.
module tb_reg_file;

  logic        Clk;
  logic        Clrn;
  logic        We;
  logic [4:0]  Wa;
  logic [31:0] D;
  logic [4:0]  Ra1;
  logic [4:0]  Ra2;
  logic [31:0] Qa;
  logic [31:0] Qb;
  logic [4:0]  Dbg_a;
  logic [31:0] Dbg_q;

  reg_file #(.WIDTH(32), .AW(5)) dut (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .We    (We),
    .Wa    (Wa),
    .D     (D),
    .Ra1   (Ra1),
    .Ra2   (Ra2),
    .Qa    (Qa),
    .Qb    (Qb),
    .Dbg_a (Dbg_a),
    .Dbg_q (Dbg_q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic [31:0] pat(input int i);
    logic [31:0] r;
    r = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
    return r;
  endfunction

  // Queue the expected values for the current addresses; the monitor samples 1 time unit later.
  task automatic check(input string nm, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [31:0] ed);
    exp_t e;
    e.name = nm;
    e.ea   = ea;
    e.eb   = eb;
    e.ed   = ed;
    exp_q.push_back(e);
    ->chk_ev;
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge Clk);
    We = 1'b1;
    Wa = a;
    D  = d;
    @(posedge Clk);
    #1;
    We = 1'b0;
  endtask

  task automatic cmp(input string nm, input string port, input logic [31:0] act,
                     input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s %s: got %h, expected %h", nm, port, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL monitor: got check request, expected a queued entry");
      end else begin
        e = exp_q.pop_front();
        cmp(e.name, "Qa", Qa, e.ea);
        cmp(e.name, "Qb", Qb, e.eb);
        cmp(e.name, "Dbg_q", Dbg_q, e.ed);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    Clrn = 1'b0;
    We = 1'b0; Wa = '0; D = '0;
    Ra1 = 5'd5; Ra2 = 5'd17; Dbg_a = 5'd31;
    #3;
    check("reset_held", 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
    Clrn = 1'b1;
    #1;
    check("reset_released", 32'h0, 32'h0, 32'h0);

    // Async reset mid-cycle clears a written value without a clock edge.
    wr(5'd5, 32'hDEADBEEF);
    Ra1 = 5'd5; Ra2 = 5'd17; Dbg_a = 5'd5;
    check("wr_r5", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    @(negedge Clk);
    #1;
    Ra2 = 5'd5;
    Clrn = 1'b0;
    #1;
    check("arst_midcycle", 32'h0, 32'h0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      Dbg_a = 5'(a);
      check("arst_dbg_sweep", 32'h0, 32'h0, 32'h0);
    end

    // Writes are blocked while reset is low, then resume once it is released.
    @(negedge Clk);
    We = 1'b1; Wa = 5'd5; D = 32'hCAFEF00D; Dbg_a = 5'd5;
    @(posedge Clk);
    #1;
    check("rst_blocks_we", 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
    Clrn = 1'b1;
    @(posedge Clk);
    #1;
    We = 1'b0;
    check("wr_after_release", 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

    // Write r7: old value before the edge, new value after.
    @(negedge Clk);
    We = 1'b1; Wa = 5'd7; D = 32'h12345678;
    Ra1 = 5'd7; Ra2 = 5'd7; Dbg_a = 5'd7;
    #1;
    check("r7_pre_edge", 32'h0, 32'h0, 32'h0);
    @(posedge Clk);
    #1;
    We = 1'b0;
    check("r7_post_edge", 32'h12345678, 32'h12345678, 32'h12345678);

    wr(5'd0, 32'hFFFFFFFF);
    Ra1 = 5'd0; Ra2 = 5'd0; Dbg_a = 5'd0;
    check("r0_protect", 32'h0, 32'h0, 32'h0);

    wr(5'd3, 32'h00000011);
    @(negedge Clk);
    We = 1'b0; Wa = 5'd3; D = 32'hA5A5A5A5;
    repeat (4) @(posedge Clk);
    #1;
    Ra1 = 5'd3; Ra2 = 5'd3; Dbg_a = 5'd3;
    check("we_gating", 32'h00000011, 32'h00000011, 32'h00000011);

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), pat(i));
    end
    for (int i = 0; i < 32; i++) begin
      Ra1 = 5'(i); Ra2 = 5'(31 - i); Dbg_a = 5'(i);
      check("sweep", pat(i), pat(31 - i), pat(i));
    end

    // Consecutive writes to r9 with D changing mid-cycle: Qb must only move at edges.
    @(negedge Clk);
    Ra1 = 5'd9; Ra2 = 5'd9; Dbg_a = 5'd9;
    We = 1'b1; Wa = 5'd9; D = 32'h1;
    #1;
    check("r9_before_n", 32'h09090909, 32'h09090909, 32'h09090909);
    @(posedge Clk);
    @(negedge Clk);
    D = 32'h2;
    #1;
    check("r9_cycle_n1", 32'h1, 32'h1, 32'h1);
    @(posedge Clk);
    #1;
    We = 1'b0;
    check("r9_after_n1", 32'h2, 32'h2, 32'h2);
    @(posedge Clk);
    #1;
    check("r9_held", 32'h2, 32'h2, 32'h2);

    #10;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
